// File: rtl/fxp_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_mac
//  Purpose  : Pipelined signed fixed-point multiply-accumulate. Accumulates
//             in*w products at full precision and, on the term flagged
//             last, emits one rounded (half-up), saturated result in the
//             input Q format. Optional ReLU clamps negative results to 0.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        rising-edge clock
//    reset      synchronous active-high reset
//    in_valid   in/w/in_last valid this cycle
//    in_last    final term of the current dot product (qualified by in_valid)
//    in, w      signed Q(DATA_W-FRAC_W).FRAC_W activation / weight
//    out        signed result in the same format, held until the next result
//    out_valid  one-cycle pulse, out is new
//    sat        out was saturated; valid with out_valid, held with out
//  Pipeline (term sampled at edge N):
//    N   input capture, N+1 product, N+2 accumulate, N+3 round/saturate
// ============================================================================
module fxp_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int RELU   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              sat
);

  localparam int PROD_W = 2 * DATA_W;

  // Saturation bounds and rounding offset, expressed in the ACC_W+1 bit
  // domain where the rounded value is evaluated.
  localparam logic signed [ACC_W:0] MAX_POS =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_NEG =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [ACC_W:0] RND_HALF =
    (ACC_W + 1)'(1) << (FRAC_W - 1);

  // Input capture stage
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic                     v0;
  logic                     l0;

  // Product stage
  logic signed [PROD_W-1:0] prod;
  logic                     v1;
  logic                     l1;

  // Accumulate stage
  logic signed [ACC_W-1:0]  acc;
  logic                     first;
  logic                     done;

  // Round / saturate (combinational, registered into out/sat)
  logic signed [ACC_W:0]    acc_ext;
  logic signed [ACC_W:0]    r;
  logic [DATA_W-1:0]        out_nxt;
  logic                     sat_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      v0        <= 1'b0;
      l0        <= 1'b0;
      prod      <= '0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      acc       <= '0;
      first     <= 1'b1;
      done      <= 1'b0;
      out       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // in_last without in_valid must never reach the pipeline.
      v0 <= in_valid;
      l0 <= in_valid & in_last;
      if (in_valid) begin
        a_q <= in;
        b_q <= w;
      end

      v1   <= v0;
      l1   <= l0;
      prod <= PROD_W'(a_q) * PROD_W'(b_q);

      // Bubbles leave acc and first untouched; the term after a last
      // restarts the sum from zero instead of clearing acc separately.
      done <= v1 & l1;
      if (v1) begin
        acc   <= (first ? '0 : acc) + ACC_W'(prod);
        first <= l1;
      end

      out_valid <= done;
      if (done) begin
        out <= out_nxt;
        sat <= sat_nxt;
      end
    end
  end

  always_comb begin
    acc_ext = (ACC_W + 1)'(acc);
    // One extra bit keeps the +half offset from wrapping near the top.
    r       = (acc_ext + RND_HALF) >>> FRAC_W;
    out_nxt = r[DATA_W-1:0];
    sat_nxt = 1'b0;
    if (r > MAX_POS) begin
      out_nxt = {1'b0, {(DATA_W - 1){1'b1}}};
      sat_nxt = 1'b1;
    end else if (r < MIN_NEG) begin
      out_nxt = {1'b1, {(DATA_W - 1){1'b0}}};
      sat_nxt = 1'b1;
    end
    if ((RELU != 0) && (r < 0)) begin
      out_nxt = '0;
      sat_nxt = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fxp_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fxp_mac
//  Purpose  : Self-checking bench for fxp_mac. Two instances share stimulus,
//             one plain and one with ReLU. A behavioural model sums products
//             as integers, rounds and saturates, and queues the expected
//             result with the cycle at which it must appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_mac;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [DATA_W-1:0] in_d = '0;
  logic [DATA_W-1:0] w_d = '0;
  logic [DATA_W-1:0] out, relu_out;
  logic              out_valid, relu_out_valid;
  logic              sat, relu_sat;

  fxp_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .RELU(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in(in_d), .w(w_d), .out(out), .out_valid(out_valid), .sat(sat)
  );

  fxp_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .RELU(1)) dut_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in(in_d), .w(w_d), .out(relu_out), .out_valid(relu_out_valid), .sat(relu_sat)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] o;
    logic              s;
    logic [DATA_W-1:0] ro;
    logic              rs;
    int unsigned       cyc;
  } exp_t;

  exp_t   q[$];
  longint sum = 0;
  bit     fresh = 1'b1;

  function automatic void round_sat(input longint a, input bit relu,
                                    output logic [DATA_W-1:0] o, output logic s);
    longint r;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (DATA_W - 1)) - 1;
    minv = -(longint'(1) << (DATA_W - 1));
    r = (a + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
    s = 1'b0;
    if (r > maxv) begin
      o = DATA_W'(maxv);
      s = 1'b1;
    end else if (r < minv) begin
      o = DATA_W'(minv);
      s = 1'b1;
    end else begin
      o = DATA_W'(r);
    end
    if (relu && r < 0) begin
      o = '0;
      s = 1'b0;
    end
  endfunction

  // Present one cycle of stimulus; called just after a rising edge.
  task automatic term(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input bit v, input bit l);
    longint prod;
    in_d     = a;
    w_d      = b;
    in_valid = v;
    in_last  = l;
    if (v) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      sum  = (fresh ? 64'sd0 : sum) + prod;
      sum  = (sum <<< (64 - ACC_W)) >>> (64 - ACC_W);
      fresh = l;
      if (l) begin
        exp_t e;
        round_sat(sum, 1'b0, e.o, e.s);
        round_sat(sum, 1'b1, e.ro, e.rs);
        // Sampled at edge cyc+1, result visible after edge cyc+4.
        e.cyc = cyc + 4;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) term('0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    sum      = 0;
    fresh    = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  logic [DATA_W-1:0] held_o = '0, held_ro = '0;
  logic              held_s = 1'b0, held_rs = 1'b0;
  exp_t              m;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_seen) begin
        check("rst_out", out, 0);
        check("rst_sat", sat, 0);
        check("rst_valid", out_valid, 0);
        check("rst_relu_valid", relu_out_valid, 0);
        held_o = '0; held_s = 1'b0; held_ro = '0; held_rs = 1'b0;
      end else if (out_valid || relu_out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", out_valid, 0);
          check("unexpected_relu_valid", relu_out_valid, 0);
        end else begin
          m = q.pop_front();
          check("latency", cyc, m.cyc);
          check("out_valid", out_valid, 1);
          check("out", out, m.o);
          check("sat", sat, m.s);
          check("relu_valid", relu_out_valid, 1);
          check("relu_out", relu_out, m.ro);
          check("relu_sat", relu_sat, m.rs);
          held_o = m.o; held_s = m.s; held_ro = m.ro; held_rs = m.rs;
        end
      end else begin
        check("hold_out", out, held_o);
        check("hold_sat", sat, held_s);
        check("hold_relu_out", relu_out, held_ro);
        check("hold_relu_sat", relu_sat, held_rs);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Positive saturation: 17.0 * 17.0
    term(16'h1100, 16'h1100, 1'b1, 1'b1);
    idle(6);
    check("pos_sat_out", out, 16'h7FFF);
    check("pos_sat_flag", sat, 1);
    check("pos_sat_relu_out", relu_out, 16'h7FFF);

    // Dot product with a bubble: 1.5*2 - 0.5*4 + 0.25*0.25 = 1.0625
    term(16'h0180, 16'h0200, 1'b1, 1'b0);
    term(16'hFF80, 16'h0400, 1'b1, 1'b0);
    idle(1);
    term(16'h0040, 16'h0040, 1'b1, 1'b1);
    idle(6);
    check("dot_out", out, 16'h0110);
    check("dot_sat", sat, 0);

    // Rounding and negative saturation
    term(16'h0001, 16'h0080, 1'b1, 1'b1);
    idle(6);
    check("rnd_up_out", out, 16'h0001);
    term(16'hFFFF, 16'h0080, 1'b1, 1'b1);
    idle(6);
    check("rnd_neg_half_out", out, 16'h0000);
    term(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    idle(6);
    check("neg_sat_out", out, 16'h8000);
    check("neg_sat_flag", sat, 1);
    check("neg_sat_relu_out", relu_out, 16'h0000);
    check("neg_sat_relu_sat", relu_sat, 0);

    // Back-to-back single-term dot products
    for (int i = 1; i <= 5; i++) term(16'h0100, 16'(i << 8), 1'b1, 1'b1);
    idle(6);
    check("b2b_last_out", out, 16'h0500);

    // Reset discards a partial sum and in-flight terms
    term(16'h0100, 16'h0100, 1'b1, 1'b0);
    term(16'h0100, 16'h0100, 1'b1, 1'b0);
    do_reset();
    term(16'h0200, 16'h0100, 1'b1, 1'b1);
    idle(6);
    check("post_reset_out", out, 16'h0200);

    // ReLU instance against negative and saturating results
    term(16'hFF00, 16'h0100, 1'b1, 1'b1);
    idle(6);
    check("relu_neg_plain_out", out, 16'hFF00);
    check("relu_neg_out", relu_out, 16'h0000);
    check("relu_neg_sat", relu_sat, 0);
    term(16'h1100, 16'h1100, 1'b1, 1'b1);
    idle(6);
    check("relu_pos_sat_out", relu_out, 16'h7FFF);
    check("relu_pos_sat_flag", relu_sat, 1);

    // Random streams: gaps, stray in_last on idle cycles, mixed magnitudes
    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] a, b;
      if ($urandom_range(0, 1) == 0) begin
        a = DATA_W'($signed($urandom_range(0, 1023)) - 512);
        b = DATA_W'($signed($urandom_range(0, 1023)) - 512);
      end else begin
        a = DATA_W'($urandom);
        b = DATA_W'($urandom);
      end
      term(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    term(16'h0100, 16'h0100, 1'b1, 1'b1);

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fxp_mac.md
Name: fxp_mac

Overview:
- Parametrised, pipelined signed fixed-point multiply-accumulate unit. Successor to the single-product 16-bit multiplier.
- Accepts a stream of (in, w) pairs and accumulates their products at full precision.
- On the pair flagged last, emits one rounded, saturated dot-product result in the input Q format.
- Neuron datapath building block: inputs × weights, optional ReLU, result fed to the next layer.

Parameters:
- DATA_W, 16: width of in, w, out; signed two's complement.
- FRAC_W, 8: fractional bits of in, w and out (default Q8.8). Legal range 1..DATA_W-1.
- ACC_W, 40: accumulator width. Must be at least 2*DATA_W; provides 2^(ACC_W-2*DATA_W) terms of headroom.
- RELU, 0: 1 = clamp negative results to zero at output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in/w/in_last valid this cycle
- in_last  in  1  final term of current dot product (qualified by in_valid)
- in  in  DATA_W  signed activation, Q(DATA_W-FRAC_W).FRAC_W
- w  in  DATA_W  signed weight, same format
- out  out  DATA_W  signed result, same format; held until next result
- out_valid  out  1  one-cycle pulse, out is new
- sat  out  1  out was saturated; valid with out_valid, held with out

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high. Port names are clk and reset.
- Reset values: out=0, out_valid=0, sat=0, accumulator=0, all pipeline valid bits=0, first-term flag=1.
- Reset mid-operation discards any partial sum and all in-flight terms. The first valid term after reset starts a new dot product.
- No backpressure: a term is accepted every cycle in_valid=1. Gaps (in_valid=0) are allowed anywhere and do not disturb the accumulation.
- Stage 1 (edge after acceptance): p = signed(in) × signed(w), full 2*DATA_W bits, registered with its valid and last bits.
- Stage 2: if p is valid, acc <= (first ? 0 : acc) + sign-extended p.
  - first <= last of that term, so the term after a last starts fresh.
  - Invalid stage: acc and first unchanged.
- Stage 3 (only when the stage-2 term had last=1):
  - r = (acc_new + 2^(FRAC_W-1)) >>> FRAC_W: arithmetic shift, round-half-up toward +inf, computed in ACC_W+1 bits.
  - If r > 2^(DATA_W-1)-1: out=max positive, sat=1.
  - Else if r < -2^(DATA_W-1): out=min negative, sat=1.
  - Else out=r[DATA_W-1:0], sat=0.
  - If RELU=1 and r<0: out=0, sat=0.
  - out_valid=1 for exactly that cycle.
- Latency: the term with in_last=1 accepted at edge N produces out_valid high in the cycle following edge N+3 (3-cycle latency).
- Throughput: back-to-back dot products are supported, including single-term ones with in_last=1 every cycle; out_valid then pulses every cycle.
- Accumulator overflow beyond ACC_W wraps (two's complement) and is not flagged; sizing is the integrator's responsibility.
- in_last with in_valid=0 is ignored.

Test Plan:
- Positive saturation: reset 16 ns, then in=0x1100, w=0x1100, in_valid=1, in_last=1 for one cycle (17.0×17.0=289.0) -> 3 cycles later out=0x7FFF, sat=1, out_valid pulse 1 cycle; out/sat hold afterwards.
- Dot product with bubbles, terms 1.5×2.0, -0.5×4.0, 0.25×0.25 (in/w = 0x0180/0x0200, 0xFF80/0x0400, 0x0040/0x0040), idle cycle between terms 2 and 3, last on term 3 -> out=0x0110 (1.0625), sat=0, exactly one out_valid.
- Rounding: in=0x0001, w=0x0080 -> out=0x0001; in=0xFFFF, w=0x0080 -> out=0x0000; in=0x8000, w=0x7FFF -> out=0x8000, sat=1.
- Back-to-back single-term results, in_last=1 every cycle for 5 cycles with in=0x0100 and w=0x0100..0x0500 -> out_valid high 5 consecutive cycles, out=0x0100..0x0500 in order.
- Reset mid-accumulation: two terms 0x0100×0x0100 without last, assert reset 1 cycle, then one term 0x0200×0x0100 with last -> out=0x0200 (partial sum discarded), no out_valid during or just after reset.
- RELU=1 build: 0xFF00×0x0100 with last -> out=0x0000, sat=0; 0x1100×0x1100 -> out=0x7FFF, sat=1.
